// File: rtl/lif_post_neuron.sv
// -----------------------------------------------------------------------------
// lif_post_neuron
//   Leaky integrate-and-fire postsynaptic neuron feeding the STDP learning stage.
//   Each cycle in INTEGRATE it adds the weights of the presynaptic inputs that
//   spiked, subtracts a shift-based leak, saturates, and compares the result
//   against THRESHOLD. A crossing clears the membrane, emits a one-cycle
//   post_spike pulse and (optionally) enters a refractory hold-off during which
//   all inputs are ignored.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   pre_spike    in   [NUM_PRE]          presynaptic spike vector
//   weights      in   [NUM_PRE*W_WIDTH]  weight i at [i*W_WIDTH +: W_WIDTH]
//   post_spike   out  registered one-cycle fire pulse
//   membrane     out  [POT_WIDTH]        registered membrane potential
//   refractory   out  high while in the REFRACT state
//   spike_count  out  [8]                fires since reset, saturating at 255
// -----------------------------------------------------------------------------
module lif_post_neuron #(
  parameter int NUM_PRE        = 5,
  parameter int W_WIDTH        = 8,
  parameter int POT_WIDTH      = 12,
  parameter int THRESHOLD      = 200,
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PRE-1:0]           pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0]   weights,
  output logic                         post_spike,
  output logic [POT_WIDTH-1:0]         membrane,
  output logic                         refractory,
  output logic [7:0]                   spike_count
);

  // Synaptic sum never overflows at SUM_W; the arithmetic width carries one
  // extra bit above the larger of sum and potential so pot - leak + sum cannot wrap.
  localparam int SUM_W  = W_WIDTH + $clog2(NUM_PRE) + 1;
  localparam int WIDE_W = ((SUM_W > POT_WIDTH) ? SUM_W : POT_WIDTH) + 1;
  localparam int CNT_W  = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  localparam logic [WIDE_W-1:0] POT_MAX  = {{(WIDE_W-POT_WIDTH){1'b0}}, {POT_WIDTH{1'b1}}};
  localparam logic [WIDE_W-1:0] THRESH_W = WIDE_W'(THRESHOLD);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(REFRACT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [POT_WIDTH-1:0] membrane_q, membrane_d;
  logic                 post_spike_q, post_spike_d;
  logic                 refractory_q, refractory_d;
  logic [7:0]           spike_count_q, spike_count_d;

  // ---------------------------------------------------------------------------
  // Synaptic integration datapath
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] masked_w [NUM_PRE];
  logic [SUM_W-1:0] syn_sum;

  for (genvar gi = 0; gi < NUM_PRE; gi++) begin : g_mask
    assign masked_w[gi] = pre_spike[gi] ? SUM_W'(weights[gi*W_WIDTH +: W_WIDTH]) : '0;
  end

  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      syn_sum = syn_sum + masked_w[i];
    end
  end

  logic [WIDE_W-1:0] pot_wide;
  logic [WIDE_W-1:0] leak_raw;
  logic [WIDE_W-1:0] leak;
  logic [WIDE_W-1:0] nxt_raw;
  logic [WIDE_W-1:0] nxt_sat;
  logic              fire;

  always_comb begin
    pot_wide = WIDE_W'(membrane_q);
    leak_raw = pot_wide >> LEAK_SHIFT;
    // A small nonzero potential would otherwise never decay: leak at least 1.
    leak     = ((leak_raw == '0) && (membrane_q != '0)) ? WIDE_W'(1) : leak_raw;
    // leak <= pot always holds, so the subtraction cannot underflow.
    nxt_raw  = pot_wide - leak + WIDE_W'(syn_sum);
    nxt_sat  = (nxt_raw > POT_MAX) ? POT_MAX : nxt_raw;
    fire     = (nxt_sat >= THRESH_W);
  end

  // ---------------------------------------------------------------------------
  // State register (all flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INTEGRATE;
      cnt_q         <= '0;
      membrane_q    <= '0;
      post_spike_q  <= 1'b0;
      refractory_q  <= 1'b0;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      membrane_q    <= membrane_d;
      post_spike_q  <= post_spike_d;
      refractory_q  <= refractory_d;
      spike_count_q <= spike_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INTEGRATE: begin
        // With no refractory period a fire simply stays in INTEGRATE.
        if (fire && (REFRACT_CYCLES > 0)) begin
          state_d = ST_REFRACT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_REFRACT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_INTEGRATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_INTEGRATE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (feeds the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    membrane_d    = membrane_q;
    post_spike_d  = 1'b0;
    spike_count_d = spike_count_q;
    case (state_q)
      ST_INTEGRATE: begin
        if (fire) begin
          membrane_d   = '0;
          post_spike_d = 1'b1;
          if (spike_count_q != 8'hFF) begin
            spike_count_d = spike_count_q + 8'd1;
          end
        end else begin
          membrane_d = nxt_sat[POT_WIDTH-1:0];
        end
      end
      ST_REFRACT: begin
        membrane_d = '0;
      end
      default: begin
        membrane_d = '0;
      end
    endcase
    // Registered copy of the state so it lines up with cnt != 0.
    refractory_d = (state_d == ST_REFRACT);
  end

  assign post_spike  = post_spike_q;
  assign membrane    = membrane_q;
  assign refractory  = refractory_q;
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_post_neuron.sv
// -----------------------------------------------------------------------------
// tb_lif_post_neuron
//   Directed bench for lif_post_neuron. Three instances cover the default
//   configuration (a), THRESHOLD=4095 (b) and REFRACT_CYCLES=0 (c). Expected
//   outputs are pushed to a scoreboard queue as each edge is driven and popped
//   and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_lif_post_neuron;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic [4:0]  pre_a, pre_b, pre_c;
  logic [39:0] wbus_a, wbus_b, wbus_c;
  logic        post_a, post_b, post_c;
  logic [11:0] mem_a, mem_b, mem_c;
  logic        refr_a, refr_b, refr_c;
  logic [7:0]  cnt_a, cnt_b, cnt_c;

  lif_post_neuron dut_a (
    .clk(clk), .rst(rst_a), .pre_spike(pre_a), .weights(wbus_a),
    .post_spike(post_a), .membrane(mem_a), .refractory(refr_a), .spike_count(cnt_a)
  );

  lif_post_neuron #(.THRESHOLD(4095)) dut_b (
    .clk(clk), .rst(rst_b), .pre_spike(pre_b), .weights(wbus_b),
    .post_spike(post_b), .membrane(mem_b), .refractory(refr_b), .spike_count(cnt_b)
  );

  lif_post_neuron #(.REFRACT_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst_c), .pre_spike(pre_c), .weights(wbus_c),
    .post_spike(post_c), .membrane(mem_c), .refractory(refr_c), .spike_count(cnt_c)
  );

  typedef struct {
    int    id;
    string tag;
    bit    post;
    int    mem;
    bit    refr;
    int    cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference behaviour of instance a (default parameters).
  int w_a [5];
  int m_pot, m_cnt, m_fires;
  bit m_post;

  function automatic void model_reset();
    m_pot = 0; m_cnt = 0; m_fires = 0; m_post = 1'b0;
  endfunction

  function automatic void model_edge(input logic [4:0] ps);
    int sum, leak, nxt;
    if (m_cnt != 0) begin
      m_post = 1'b0;
      m_pot  = 0;
      m_cnt  = m_cnt - 1;
    end else begin
      sum = 0;
      for (int i = 0; i < 5; i++) if (ps[i]) sum += w_a[i];
      leak = m_pot >> 3;
      if (leak == 0 && m_pot != 0) leak = 1;
      nxt = m_pot - leak + sum;
      if (nxt > 4095) nxt = 4095;
      if (nxt >= 200) begin
        m_pot = 0; m_post = 1'b1; m_cnt = 4;
        if (m_fires < 255) m_fires++;
      end else begin
        m_pot = nxt; m_post = 1'b0;
      end
    end
  endfunction

  task automatic set_wa();
    for (int i = 0; i < 5; i++) wbus_a[i*8 +: 8] = 8'(w_a[i]);
  endtask

  task automatic push(input int id, input string tag, input bit p, input int m, input bit r, input int c);
    exp_t e;
    e.id = id; e.tag = tag; e.post = p; e.mem = m; e.refr = r; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic push_model(input string tag);
    push(0, tag, m_post, m_pot, (m_cnt != 0), m_fires);
  endtask

  task automatic check_all();
    exp_t e;
    logic p, r;
    logic [11:0] m;
    logic [7:0] c;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin p = post_a; m = mem_a; r = refr_a; c = cnt_a; end
        1:       begin p = post_b; m = mem_b; r = refr_b; c = cnt_b; end
        default: begin p = post_c; m = mem_c; r = refr_c; c = cnt_c; end
      endcase
      checks++;
      assert (p === e.post) else begin
        errors++; $error("FAIL %s post_spike observed %0d expected %0d", e.tag, p, e.post);
      end
      checks++;
      assert (m === 12'(e.mem)) else begin
        errors++; $error("FAIL %s membrane observed %0d expected %0d", e.tag, m, e.mem);
      end
      checks++;
      assert (r === e.refr) else begin
        errors++; $error("FAIL %s refractory observed %0d expected %0d", e.tag, r, e.refr);
      end
      checks++;
      assert (c === 8'(e.cnt)) else begin
        errors++; $error("FAIL %s spike_count observed %0d expected %0d", e.tag, c, e.cnt);
      end
      $display("txn dut%0d %s post=%0d mem=%0d refr=%0d cnt=%0d", e.id, e.tag, p, m, r, c);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic step_a(input logic [4:0] ps, input string tag);
    pre_a = ps;
    model_edge(ps);
    push_model(tag);
    step();
  endtask

  task automatic chk_mem_a(input string tag, input int exp_v);
    checks++;
    assert (mem_a === 12'(exp_v)) else begin
      errors++; $error("FAIL %s membrane observed %0d expected %0d", tag, mem_a, exp_v);
    end
  endtask

  initial begin
    int decay_exp [5];
    decay_exp = '{80, 70, 62, 55, 49};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    pre_a = '0; pre_b = '0; pre_c = '0;
    for (int i = 0; i < 5; i++) w_a[i] = 50;
    set_wa();
    wbus_b = {5{8'd255}};
    wbus_c = {5{8'd50}};
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_model("reset");
    check_all();
    @(negedge clk);
    rst_a = 1'b0;

    // Single all-spike edge: 250 >= 200 fires once, then refractory for 4 cycles
    step_a(5'b11111, "single_fire");
    for (int k = 0; k < 4; k++) step_a(5'b00000, "single_refract");
    step_a(5'b00000, "single_after");

    // Decay trace from one 80-weight pulse, down to exactly 0 without firing
    w_a[0] = 80;
    set_wa();
    for (int k = 0; k < 5; k++) begin
      step_a((k == 0) ? 5'b00001 : 5'b00000, "decay");
      chk_mem_a("decay_const", decay_exp[k]);
    end
    for (int k = 0; k < 60; k++) step_a(5'b00000, "decay_idle");
    chk_mem_a("decay_zero", 0);

    // Held drive: fires on edges 1, 6, 11
    w_a[0] = 50;
    set_wa();
    for (int k = 0; k < 11; k++) step_a(5'b11111, "held");

    // Async reset right after a fire (pulse high, refractory) clears immediately
    #2;
    rst_a = 1'b1;
    model_reset();
    #1;
    push_model("async_rst");
    check_all();
    @(negedge clk);
    rst_a = 1'b0;
    step_a(5'b11111, "post_rst_fire");
    pre_a = '0;

    // Instance b (THRESHOLD=4095) and c (no refractory) driven together
    @(negedge clk);
    rst_b = 1'b0;
    rst_c = 1'b0;
    pre_b = 5'b11111;
    pre_c = 5'b11111;
    for (int n = 1; n <= 260; n++) begin
      case (n)
        1: push(1, "sat_1", 1'b0, 1275, 1'b0, 0);
        2: push(1, "sat_2", 1'b0, 2391, 1'b0, 0);
        3: push(1, "sat_3", 1'b0, 3368, 1'b0, 0);
        4: push(1, "sat_fire", 1'b1, 0, 1'b1, 1);
        default: ;
      endcase
      push(2, "norefract", 1'b1, 0, 1'b0, (n > 255) ? 255 : n);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
